// File: rtl/inst_cache_pkg.sv
// inst_cache_pkg: shared geometry, FSM encoding and block-to-instruction extraction for inst_cache
package inst_cache_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int BLOCK_WIDTH = 1;
  localparam int BLOCK_SIZE = 1 << BLOCK_WIDTH;
  localparam int CACHE_WIDTH = 8;
  localparam int BLOCK_NUM = 1 << CACHE_WIDTH;
  localparam int TAG_WIDTH = ADDR_WIDTH - CACHE_WIDTH - BLOCK_WIDTH - 2;
  localparam int BLK_BITS = 32 * BLOCK_SIZE;
  localparam int IDX_LSB = 2 + BLOCK_WIDTH;
  localparam int TAG_LSB = IDX_LSB + CACHE_WIDTH;
  typedef enum logic {IDLE = 1'b0, MISS = 1'b1} state_t;
  function automatic logic [31:0] get_inst(input logic [BLK_BITS-1:0] blk, input logic [BLOCK_WIDTH-1:0] k);
    logic [31:0] w;
    w = 32'(blk >> (32 * (BLOCK_SIZE - 1 - int'(k))));
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
endpackage

// File: rtl/inst_cache_if.sv
// inst_cache_if: IF fetch and MC block-fill bus; master = cache side, slave = IF/MC side
import inst_cache_pkg::*;
interface inst_cache_if;
  logic IFIC_en;
  logic [ADDR_WIDTH-1:0] IFIC_addr;
  logic RoB_clear;
  logic ICIF_en;
  logic [31:0] ICIF_inst;
  logic ICMC_en;
  logic [ADDR_WIDTH-1:0] ICMC_addr;
  logic MCIC_en;
  logic [BLK_BITS-1:0] MCIC_block;
  modport master (input IFIC_en, IFIC_addr, RoB_clear, MCIC_en, MCIC_block, output ICIF_en, ICIF_inst, ICMC_en, ICMC_addr);
  modport slave (output IFIC_en, IFIC_addr, RoB_clear, MCIC_en, MCIC_block, input ICIF_en, ICIF_inst, ICMC_en, ICMC_addr);
endinterface

// File: rtl/inst_cache_array.sv
// inst_cache_array: valid/tag/data storage; comb read by index, sync write, async clear of valid bits
import inst_cache_pkg::*;
module inst_cache_array (
  input  logic Sys_clk,
  input  logic Sys_rst_n,
  input  logic we,
  input  logic [CACHE_WIDTH-1:0] rd_idx,
  input  logic [CACHE_WIDTH-1:0] wr_idx,
  input  logic [TAG_WIDTH-1:0] wr_tag,
  input  logic [BLK_BITS-1:0] wr_data,
  output logic rd_valid,
  output logic [TAG_WIDTH-1:0] rd_tag,
  output logic [BLK_BITS-1:0] rd_data
);
  logic [BLOCK_NUM-1:0] valid;
  logic [TAG_WIDTH-1:0] tags [BLOCK_NUM];
  logic [BLK_BITS-1:0] data [BLOCK_NUM];
  assign rd_valid = valid[rd_idx];
  assign rd_tag = tags[rd_idx];
  assign rd_data = data[rd_idx];
  always_ff @(posedge Sys_clk or negedge Sys_rst_n)
    if (!Sys_rst_n) valid <= '0;
    else if (we) valid[wr_idx] <= 1'b1;
  always_ff @(posedge Sys_clk)
    if (we) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
endmodule

// File: rtl/inst_cache.sv
// inst_cache: direct-mapped read-only I-cache (Sys_clk, Sys_rst_n, Sys_rdy enable, bus = IF/MC interface)
import inst_cache_pkg::*;
module inst_cache (
  input logic Sys_clk,
  input logic Sys_rst_n,
  input logic Sys_rdy,
  inst_cache_if.master bus
);
  state_t state, state_n;
  logic drop, req_ok, hit, miss_start, fill, resp_hit, resp_fill, if_en, rd_valid, unused_addr;
  logic [31:0] if_inst;
  logic [ADDR_WIDTH-1:2] req_addr;
  logic [TAG_WIDTH-1:0] rd_tag;
  logic [BLK_BITS-1:0] rd_data;
  assign unused_addr = ^bus.IFIC_addr[1:0];
  inst_cache_array u_array (
    .Sys_clk(Sys_clk),
    .Sys_rst_n(Sys_rst_n),
    .we(fill && Sys_rdy),
    .rd_idx(bus.IFIC_addr[IDX_LSB +: CACHE_WIDTH]),
    .wr_idx(req_addr[IDX_LSB +: CACHE_WIDTH]),
    .wr_tag(req_addr[TAG_LSB +: TAG_WIDTH]),
    .wr_data(bus.MCIC_block),
    .rd_valid(rd_valid),
    .rd_tag(rd_tag),
    .rd_data(rd_data)
  );
  assign req_ok = bus.IFIC_en && !bus.RoB_clear;
  assign hit = rd_valid && rd_tag == bus.IFIC_addr[TAG_LSB +: TAG_WIDTH];
  assign miss_start = state == IDLE && req_ok && !hit;
  assign fill = state == MISS && bus.MCIC_en;
  assign resp_hit = state == IDLE && req_ok && hit;
  assign resp_fill = fill && !drop && !bus.RoB_clear;
  assign bus.ICMC_en = state == MISS && !bus.MCIC_en;
  assign bus.ICMC_addr = {req_addr[ADDR_WIDTH-1:IDX_LSB], IDX_LSB'(0)};
  assign bus.ICIF_en = if_en;
  assign bus.ICIF_inst = if_inst;
  always_comb begin
    state_n = state == IDLE ? (miss_start ? MISS : IDLE) : (bus.MCIC_en ? IDLE : MISS);
  end
  always_ff @(posedge Sys_clk or negedge Sys_rst_n)
    if (!Sys_rst_n) state <= IDLE;
    else if (Sys_rdy) state <= state_n;
  always_ff @(posedge Sys_clk or negedge Sys_rst_n)
    if (!Sys_rst_n) begin
      if_en <= 1'b0;
      if_inst <= '0;
      req_addr <= '0;
      drop <= 1'b0;
    end else if (Sys_rdy) begin
      if_en <= resp_hit || resp_fill;
      if (resp_hit || resp_fill)
        if_inst <= resp_fill ? get_inst(bus.MCIC_block, req_addr[2 +: BLOCK_WIDTH]) : get_inst(rd_data, bus.IFIC_addr[2 +: BLOCK_WIDTH]);
      if (miss_start) req_addr <= bus.IFIC_addr[ADDR_WIDTH-1:2];
      drop <= miss_start ? 1'b0 : (state == MISS && bus.RoB_clear) ? 1'b1 : drop;
    end
endmodule
